// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I/RV32E core: FETCH/EXEC/MEM sequencer sharing one memory port,
// with halt/trap status, retired-instruction counter and a debug register read port.
module rv32_multicycle_core #(
    parameter int unsigned NUM_REGS     = 32,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        halted,
    output logic        trap,
    output logic [31:0] instret,
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [2:0]  mem_funct3_q, mem_funct3_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        halted_q, halted_d;
    logic        trap_q, trap_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] regs_q [NUM_REGS];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // x0 and indices beyond the implemented file read as zero
    function automatic logic [31:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0 || 32'(idx) >= NUM_REGS) return '0;
        return regs_q[idx[AW-1:0]];
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] f, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000:  return alt ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'b0, $signed(a) < $signed(b)};
            3'b011:  return {31'b0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;

    assign opcode  = ir_q[6:0];
    assign rd      = ir_q[11:7];
    assign funct3  = ir_q[14:12];
    assign rs1     = ir_q[19:15];
    assign rs2     = ir_q[24:20];
    assign funct7  = ir_q[31:25];
    assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u   = {ir_q[31:12], 12'b0};
    assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign rs1_val = rf_read(rs1);
    assign rs2_val = rf_read(rs2);

    logic        illegal, misalign, wb_en, is_mem, is_store, taken, chk_target;
    logic        uses_rd, uses_rs1, uses_rs2;
    logic [31:0] wb_val, next_pc, eff;

    // Decode the held instruction: legality, writeback value, next pc and memory address
    always_comb begin
        illegal    = 1'b0;
        misalign   = 1'b0;
        wb_en      = 1'b0;
        wb_val     = '0;
        is_mem     = 1'b0;
        is_store   = 1'b0;
        taken      = 1'b0;
        chk_target = 1'b0;
        uses_rd    = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        next_pc    = pc_q + 32'd4;
        eff        = '0;
        case (opcode)
            OPC_LUI: begin
                uses_rd = 1'b1; wb_en = 1'b1; wb_val = imm_u;
            end
            OPC_AUIPC: begin
                uses_rd = 1'b1; wb_en = 1'b1; wb_val = pc_q + imm_u;
            end
            OPC_JAL: begin
                uses_rd = 1'b1; wb_en = 1'b1; wb_val = pc_q + 32'd4;
                next_pc = pc_q + imm_j; chk_target = 1'b1;
            end
            OPC_JALR: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1; wb_en = 1'b1; wb_val = pc_q + 32'd4;
                illegal = (funct3 != 3'b000);
                next_pc = (rs1_val + imm_i) & ~32'd1; chk_target = 1'b1;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                case (funct3)
                    3'b000:  taken = (rs1_val == rs2_val);
                    3'b001:  taken = (rs1_val != rs2_val);
                    3'b100:  taken = ($signed(rs1_val) < $signed(rs2_val));
                    3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
                    3'b110:  taken = (rs1_val < rs2_val);
                    3'b111:  taken = (rs1_val >= rs2_val);
                    default: illegal = 1'b1;
                endcase
                if (taken) next_pc = pc_q + imm_b;
                chk_target = taken;
            end
            OPC_LOAD: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1; is_mem = 1'b1;
                eff     = rs1_val + imm_i;
                illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_mem = 1'b1; is_store = 1'b1;
                eff     = rs1_val + imm_s;
                illegal = (funct3[2] || funct3 == 3'b011);
            end
            OPC_OPIMM: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1; wb_en = 1'b1;
                if (funct3 == 3'b001) illegal = (funct7 != 7'b0000000);
                if (funct3 == 3'b101) illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                wb_val = alu(funct3, (funct3 == 3'b101) && funct7[5], rs1_val, imm_i);
            end
            OPC_OP: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; wb_en = 1'b1;
                illegal = !((funct7 == 7'b0000000) ||
                            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
                wb_val  = alu(funct3, funct7[5], rs1_val, rs2_val);
            end
            default: illegal = 1'b1;
        endcase
        if ((uses_rd && 32'(rd) >= NUM_REGS) || (uses_rs1 && 32'(rs1) >= NUM_REGS) ||
            (uses_rs2 && 32'(rs2) >= NUM_REGS))
            illegal = 1'b1;
        if (chk_target && next_pc[1]) misalign = 1'b1;
        if (is_mem && ((funct3[1:0] == 2'b01 && eff[0]) || (funct3[1:0] == 2'b10 && eff[1:0] != 2'b00)))
            misalign = 1'b1;
    end

    // Sequencer: next state, registered memory request and architectural updates
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_funct3_d = mem_funct3_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        halted_d     = halted_q;
        trap_d       = trap_q;
        instret_d    = instret_q;
        rf_we        = 1'b0;
        rf_waddr     = rd;
        rf_wdata     = wb_val;
        case (state_q)
            S_FETCH: begin
                // Request is issued one cycle after reset; otherwise EXEC/MEM already raised it
                if (!mem_req_q) begin
                    mem_req_d = 1'b1; mem_we_d = 1'b0; mem_funct3_d = 3'b010; mem_addr_d = pc_q;
                end else if (mem_ready) begin
                    ir_d = mem_rdata; mem_req_d = 1'b0; state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (HALT_ON_ZERO && ir_q == '0) begin
                    state_d = S_HALT; halted_d = 1'b1;
                end else if (illegal || misalign) begin
                    state_d = S_HALT; halted_d = 1'b1; trap_d = 1'b1;
                end else if (is_mem) begin
                    mem_req_d = 1'b1; mem_we_d = is_store; mem_funct3_d = funct3;
                    mem_addr_d = eff; mem_wdata_d = rs2_val; state_d = S_MEM;
                end else begin
                    rf_we = wb_en; pc_d = next_pc; instret_d = instret_q + 32'd1;
                    mem_req_d = 1'b1; mem_we_d = 1'b0; mem_funct3_d = 3'b010;
                    mem_addr_d = next_pc; state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    rf_we = !mem_we_q; rf_wdata = mem_rdata;
                    pc_d = pc_q + 32'd4; instret_d = instret_q + 32'd1;
                    mem_req_d = 1'b1; mem_we_d = 1'b0; mem_funct3_d = 3'b010;
                    mem_addr_d = pc_q + 32'd4; state_d = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    // State register, register file and output flops with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_funct3_q <= 3'b010;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            halted_q     <= 1'b0;
            trap_q       <= 1'b0;
            instret_q    <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_funct3_q <= mem_funct3_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            halted_q     <= halted_d;
            trap_q       <= trap_d;
            instret_q    <= instret_d;
            if (rf_we && rf_waddr != 5'd0) regs_q[rf_waddr[AW-1:0]] <= rf_wdata;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_funct3 = mem_funct3_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign pc         = pc_q;
    assign halted     = halted_q;
    assign trap       = trap_q;
    assign instret    = instret_q;
    assign dbg_data   = rf_read(dbg_sel);

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Bench for rv32_multicycle_core: program ROM + data memory model, store scoreboard,
// wait-state stability monitor, and a second RV32E instance.
module tb_rv32_multicycle_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, halted, trap;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instret, dbg_data;
    logic [4:0]  dbg_sel = 5'd0;

    logic        req16, we16, halted16, trap16;
    logic [2:0]  f3_16;
    logic [31:0] addr16, wdata16, rdata16, pc16, instret16, dbg16;
    logic [4:0]  dbg_sel16 = 5'd0;

    rv32_multicycle_core #(.NUM_REGS(32), .RESET_PC(32'h200), .HALT_ON_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .halted(halted), .trap(trap), .instret(instret), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data));

    rv32_multicycle_core #(.NUM_REGS(16), .RESET_PC(32'h40), .HALT_ON_ZERO(1'b1)) dut16 (
        .clk(clk), .rst_n(rst_n), .mem_req(req16), .mem_we(we16), .mem_funct3(f3_16),
        .mem_addr(addr16), .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ready(req16),
        .pc(pc16), .halted(halted16), .trap(trap16), .instret(instret16), .dbg_sel(dbg_sel16),
        .dbg_data(dbg16));

    // addi x20,x0,1 at the RV32E core's reset vector
    assign rdata16 = (addr16 == 32'h40) ? 32'h00100A13 : 32'h0;

    int checks = 0;
    int failures = 0;
    int rd_delay = 0;

    logic [31:0] rom [0:255];
    logic [7:0]  dmem [0:255];
    int          wcnt;

    typedef struct { logic [31:0] addr; logic [31:0] data; logic [2:0] f3; } st_t;
    st_t obs_q[$];
    st_t exp_q[$];

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // Memory read: ROM above 0x100, sized/extended data bytes below
    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] f3);
        logic [7:0] b0, b1, b2, b3;
        if (a >= 32'h100) return rom[a[9:2]];
        b0 = dmem[a[7:0]]; b1 = dmem[a[7:0] + 8'd1];
        b2 = dmem[a[7:0] + 8'd2]; b3 = dmem[a[7:0] + 8'd3];
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b100:  return {24'h0, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    assign mem_rdata = mem_read(mem_addr, mem_funct3);
    assign mem_ready = mem_req && (mem_we || wcnt >= rd_delay);

    always @(posedge clk) begin
        if (!rst_n || !(mem_req && !mem_ready)) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (rst_n && mem_req && mem_ready && mem_we) begin
            dmem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_funct3 != 3'b000) dmem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
            if (mem_funct3 == 3'b010) begin
                dmem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
                dmem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
            end
            obs_q.push_back('{mem_addr, mem_wdata, mem_funct3});
        end
    end

    logic        prev_wait;
    logic        p_we;
    logic [2:0]  p_f3;
    logic [31:0] p_addr, p_wd;
    int          run_len, max_wait, stab_viol;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wait <= 1'b0; run_len <= 0; max_wait <= 0; stab_viol <= 0;
        end else begin
            if (prev_wait && (!mem_req || mem_we !== p_we || mem_funct3 !== p_f3 ||
                              mem_addr !== p_addr || mem_wdata !== p_wd))
                stab_viol <= stab_viol + 1;
            prev_wait <= mem_req && !mem_ready;
            p_we <= mem_we; p_f3 <= mem_funct3; p_addr <= mem_addr; p_wd <= mem_wdata;
            if (mem_req && !mem_ready) begin
                run_len <= run_len + 1;
                if (run_len + 1 > max_wait) max_wait <= run_len + 1;
            end else run_len <= 0;
        end
    end

    task automatic load_prog(input logic [31:0] words[$]);
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        foreach (words[i]) rom[8'h80 + 8'(i)] = words[i];
    endtask

    task automatic restart(input int delay);
        rst_n = 1'b0; rd_delay = delay;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input int max, output int cycles);
        cycles = 0;
        while (!halted && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (!halted) begin
            failures++;
            $display("FAIL halt_timeout got=halted=%0b exp=halted within %0d cycles", halted, max);
        end
    endtask

    task automatic test_reset;
        int cyc;
        load_prog('{32'hFFB00093, 32'h0});
        rst_n = 1'b0; rd_delay = 0;
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_funct3 !== 3'b010) begin failures++; $display("FAIL rst_funct3 got=%b exp=010", mem_funct3); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
        checks++; if (pc !== 32'h200) begin failures++; $display("FAIL rst_pc got=%h exp=200", pc); end
        checks++; if (halted !== 1'b0 || trap !== 1'b0) begin failures++; $display("FAIL rst_status got=%b%b exp=00", halted, trap); end
        checks++; if (instret !== 32'h0) begin failures++; $display("FAIL rst_instret got=%h exp=0", instret); end
        checks++; if (pc16 !== 32'h40) begin failures++; $display("FAIL rst_pc16 got=%h exp=40", pc16); end
        rst_n = 1'b1;
        run_until_halt(100, cyc);
        checks++; if (cyc != 5) begin failures++; $display("FAIL halt_latency got=%0d exp=5", cyc); end
        dbg_sel = 5'd1; #1;
        checks++; if (dbg_data !== 32'hFFFF_FFFB) begin failures++; $display("FAIL addi_neg got=%h exp=fffffffb", dbg_data); end
        checks++; if (trap !== 1'b0) begin failures++; $display("FAIL zero_halt_trap got=%b exp=0", trap); end
        checks++; if (instret !== 32'd1) begin failures++; $display("FAIL zero_halt_instret got=%0d exp=1", instret); end
        repeat (3) @(negedge clk);
        checks++; if (mem_req !== 1'b0 || pc !== 32'h204) begin failures++; $display("FAIL halt_frozen got=req%b pc%h exp=req0 pc204", mem_req, pc); end
    endtask

    task automatic test_alu;
        int cyc;
        logic [4:0]  sels [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
        logic [31:0] exps [9] = '{32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hF, 32'h1, 32'h1,
                                  32'h10, 32'h1234_5000, 32'h1220};
        load_prog('{enc_i(12'hFF0, 5'd0, 3'd0, 5'd1, 7'h13),      // addi x1,x0,-16
                    enc_i(12'h402, 5'd1, 3'd5, 5'd2, 7'h13),      // srai x2,x1,2
                    enc_i(12'h01C, 5'd1, 3'd5, 5'd3, 7'h13),      // srli x3,x1,28
                    enc_i(12'h001, 5'd1, 3'd2, 5'd4, 7'h13),      // slti x4,x1,1
                    enc_i(12'hFFF, 5'd1, 3'd3, 5'd5, 7'h13),      // sltiu x5,x1,-1
                    {7'h20, 5'd1, 5'd0, 3'd0, 5'd6, 7'h33},       // sub x6,x0,x1
                    enc_i(12'h005, 5'd0, 3'd0, 5'd0, 7'h13),      // addi x0,x0,5
                    {20'h12345, 5'd7, 7'h37},                     // lui x7,0x12345
                    {20'h00001, 5'd8, 7'h17},                     // auipc x8,1
                    32'h0});
        restart(0);
        run_until_halt(200, cyc);
        for (int i = 0; i < 9; i++) begin
            dbg_sel = sels[i]; #1;
            checks++;
            if (dbg_data !== exps[i]) begin failures++; $display("FAIL alu_x%0d got=%h exp=%h", sels[i], dbg_data, exps[i]); end
        end
        checks++; if (instret !== 32'd9) begin failures++; $display("FAIL alu_instret got=%0d exp=9", instret); end
    endtask

    task automatic test_load_store(input int delay, input int exp_cycles);
        int cyc, base;
        st_t o, e;
        base = obs_q.size();
        load_prog('{enc_i(12'h055, 5'd0, 3'd0, 5'd2, 7'h13),      // addi x2,x0,0x55
                    enc_s(12'h008, 5'd2, 5'd0, 3'd2),             // sw x2,8(x0)
                    enc_i(12'h008, 5'd0, 3'd2, 5'd3, 7'h03),      // lw x3,8(x0)
                    enc_i(12'hF80, 5'd0, 3'd0, 5'd4, 7'h13),      // addi x4,x0,-128
                    enc_s(12'h00C, 5'd4, 5'd0, 3'd0),             // sb x4,12(x0)
                    enc_i(12'h00C, 5'd0, 3'd0, 5'd5, 7'h03),      // lb x5,12(x0)
                    enc_i(12'h00C, 5'd0, 3'd4, 5'd6, 7'h03),      // lbu x6,12(x0)
                    32'h0});
        exp_q.push_back('{32'h8, 32'h55, 3'b010});
        exp_q.push_back('{32'hC, 32'hFFFF_FF80, 3'b000});
        restart(delay);
        run_until_halt(400, cyc);
        checks++; if (cyc != exp_cycles) begin failures++; $display("FAIL ls_latency_d%0d got=%0d exp=%0d", delay, cyc, exp_cycles); end
        checks++; if (obs_q.size() - base != exp_q.size()) begin failures++; $display("FAIL ls_store_count got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            if (base + k < obs_q.size()) begin
                o = obs_q[base + k];
                checks++;
                if (o.addr !== e.addr || o.data !== e.data || o.f3 !== e.f3) begin
                    failures++;
                    $display("FAIL store_%0d got=a%h d%h f%b exp=a%h d%h f%b", k, o.addr, o.data, o.f3, e.addr, e.data, e.f3);
                end
            end
        end
        dbg_sel = 5'd3; #1;
        checks++; if (dbg_data !== 32'h55) begin failures++; $display("FAIL lw_x3 got=%h exp=55", dbg_data); end
        dbg_sel = 5'd5; #1;
        checks++; if (dbg_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_x5 got=%h exp=ffffff80", dbg_data); end
        dbg_sel = 5'd6; #1;
        checks++; if (dbg_data !== 32'h80) begin failures++; $display("FAIL lbu_x6 got=%h exp=80", dbg_data); end
        checks++; if (instret !== 32'd7) begin failures++; $display("FAIL ls_instret got=%0d exp=7", instret); end
        checks++; if (max_wait != delay) begin failures++; $display("FAIL wait_len got=%0d exp=%0d", max_wait, delay); end
        checks++; if (stab_viol != 0) begin failures++; $display("FAIL wait_stable got=%0d exp=0", stab_viol); end
    endtask

    task automatic test_branch_loop;
        int cyc;
        load_prog('{enc_i(12'h004, 5'd0, 3'd0, 5'd5, 7'h13),      // addi x5,x0,4
                    enc_i(12'h001, 5'd1, 3'd0, 5'd1, 7'h13),      // addi x1,x1,1
                    enc_b(13'h1FFC, 5'd5, 5'd1, 3'd1),            // bne x1,x5,-4
                    32'h0});
        restart(0);
        run_until_halt(200, cyc);
        dbg_sel = 5'd1; #1;
        checks++; if (dbg_data !== 32'd4) begin failures++; $display("FAIL loop_x1 got=%h exp=4", dbg_data); end
        checks++; if (pc !== 32'h20C) begin failures++; $display("FAIL loop_pc got=%h exp=20c", pc); end
        checks++; if (instret !== 32'd9) begin failures++; $display("FAIL loop_instret got=%0d exp=9", instret); end
        checks++; if (cyc != 21) begin failures++; $display("FAIL loop_latency got=%0d exp=21", cyc); end
    endtask

    task automatic test_jumps;
        int cyc;
        load_prog('{enc_i(12'h100, 5'd0, 3'd0, 5'd2, 7'h13),      // addi x2,x0,0x100
                    enc_i(12'h005, 5'd2, 3'd0, 5'd1, 7'h67),      // jalr x1,5(x2)
                    32'h0});
        restart(0);
        run_until_halt(200, cyc);
        dbg_sel = 5'd1; #1;
        checks++; if (pc !== 32'h104) begin failures++; $display("FAIL jalr_pc got=%h exp=104", pc); end
        checks++; if (dbg_data !== 32'h208) begin failures++; $display("FAIL jalr_link got=%h exp=208", dbg_data); end
        checks++; if (trap !== 1'b0 || instret !== 32'd2) begin failures++; $display("FAIL jalr_status got=t%b i%0d exp=t0 i2", trap, instret); end
        load_prog('{enc_j(21'h000102, 5'd1), 32'h0});              // jal x1,0x102
        restart(0);
        run_until_halt(200, cyc);
        dbg_sel = 5'd1; #1;
        checks++; if (trap !== 1'b1) begin failures++; $display("FAIL jal_misalign_trap got=%b exp=1", trap); end
        checks++; if (pc !== 32'h200) begin failures++; $display("FAIL jal_misalign_pc got=%h exp=200", pc); end
        checks++; if (dbg_data !== 32'h0 || instret !== 32'h0) begin failures++; $display("FAIL jal_misalign_state got=x1 %h i%0d exp=x1 0 i0", dbg_data, instret); end
    endtask

    task automatic test_reset_mid_mem;
        int n;
        load_prog('{enc_i(12'h008, 5'd0, 3'd2, 5'd3, 7'h03), 32'h0});
        restart(3);
        n = 0;
        while (!(mem_req && !mem_we && mem_addr == 32'h8) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(mem_req && mem_addr == 32'h8)) begin failures++; $display("FAIL reach_mem got=req%b a%h exp=req1 a8", mem_req, mem_addr); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL midmem_req got=%b exp=0", mem_req); end
        checks++; if (pc !== 32'h200 || mem_addr !== 32'h0) begin failures++; $display("FAIL midmem_pc got=%h a%h exp=200 a0", pc, mem_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_rv32e;
        int n;
        load_prog('{32'h0});
        restart(0);
        n = 0;
        while (!halted16 && n < 30) begin
            @(negedge clk);
            n++;
        end
        dbg_sel16 = 5'd20; #1;
        checks++; if (halted16 !== 1'b1 || trap16 !== 1'b1) begin failures++; $display("FAIL e_trap got=h%b t%b exp=h1 t1", halted16, trap16); end
        checks++; if (pc16 !== 32'h40 || instret16 !== 32'h0) begin failures++; $display("FAIL e_state got=pc%h i%0d exp=pc40 i0", pc16, instret16); end
        checks++; if (dbg16 !== 32'h0) begin failures++; $display("FAIL e_dbg20 got=%h exp=0", dbg16); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store(0, 22);
        test_load_store(3, 55);
        test_branch_loop();
        test_jumps();
        test_reset_mid_mem();
        test_rv32e();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
